// File: rtl/writeback_unit.sv
// Write-back stage: retires instructions from EX/MEM, drives the decoder's register-write port,
// formats load data by funct3/byte offset and flags loads whose data never arrives.
module writeback_unit #(
   parameter int XLEN         = 32,
   parameter int REG_ADDR_W   = 5,
   parameter int LOAD_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_reg_write,
   input  logic                  in_reg_write_from_load,
   input  logic [REG_ADDR_W-1:0] in_rd,
   input  logic [XLEN-1:0]       in_alu_result,
   input  logic [2:0]            in_funct3,
   input  logic [XLEN-1:0]       in_pc_value,
   input  logic                  mem_rvalid,
   input  logic [XLEN-1:0]       mem_rdata,
   output logic [REG_ADDR_W-1:0] reg_write_dest,
   output logic                  need_to_write,
   output logic [XLEN-1:0]       reg_write_dest_value,
   output logic                  retire_valid,
   output logic [XLEN-1:0]       retired_pc,
   output logic                  load_timeout_err
);

   localparam int CNT_W = (LOAD_TIMEOUT < 2) ? 1 : $clog2(LOAD_TIMEOUT + 1);
   localparam logic [0:0] IDLE      = 1'b0;
   localparam logic [0:0] LOAD_WAIT = 1'b1;
   // Counter holds completed wait cycles, so the last allowed cycle sees LOAD_TIMEOUT-1.
   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(LOAD_TIMEOUT - 1);

   logic [0:0]            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [REG_ADDR_W-1:0] rd_cap_q, rd_cap_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [1:0]            off_q, off_d;
   logic [XLEN-1:0]       pc_cap_q, pc_cap_d;
   logic [REG_ADDR_W-1:0] dest_q, dest_d;
   logic                  need_q, need_d;
   logic [XLEN-1:0]       value_q, value_d;
   logic                  retire_q, retire_d;
   logic [XLEN-1:0]       rpc_q, rpc_d;
   logic                  err_q, err_d;

   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;
   logic [XLEN-1:0]       ld_value;

   always_comb begin
      ld_byte = mem_rdata[7:0];
      case (off_q)
         2'd0:    ld_byte = mem_rdata[7:0];
         2'd1:    ld_byte = mem_rdata[15:8];
         2'd2:    ld_byte = mem_rdata[23:16];
         default: ld_byte = mem_rdata[31:24];
      endcase
      ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (funct3_q)
         3'b000:  ld_value = {{(XLEN-8){ld_byte[7]}}, ld_byte};
         3'b001:  ld_value = {{(XLEN-16){ld_half[15]}}, ld_half};
         3'b100:  ld_value = {{(XLEN-8){1'b0}}, ld_byte};
         3'b101:  ld_value = {{(XLEN-16){1'b0}}, ld_half};
         default: ld_value = mem_rdata;
      endcase
   end

   assign in_ready = (state_q == IDLE);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rd_cap_d = rd_cap_q;
      funct3_d = funct3_q;
      off_d    = off_q;
      pc_cap_d = pc_cap_q;
      dest_d   = dest_q;
      need_d   = 1'b0;
      value_d  = value_q;
      retire_d = 1'b0;
      rpc_d    = rpc_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (in_reg_write_from_load) begin
                  rd_cap_d = in_rd;
                  funct3_d = in_funct3;
                  off_d    = in_alu_result[1:0];
                  pc_cap_d = in_pc_value;
                  cnt_d    = '0;
                  state_d  = LOAD_WAIT;
               end else begin
                  retire_d = 1'b1;
                  need_d   = in_reg_write && (in_rd != '0);
                  dest_d   = in_rd;
                  value_d  = in_alu_result;
                  rpc_d    = in_pc_value;
               end
            end
         end
         LOAD_WAIT: begin
            if (mem_rvalid) begin
               retire_d = 1'b1;
               need_d   = (rd_cap_q != '0);
               dest_d   = rd_cap_q;
               value_d  = ld_value;
               rpc_d    = pc_cap_q;
               state_d  = IDLE;
            end else if (cnt_q == LAST_WAIT) begin
               // Abandoned load still retires so the PC stream stays complete.
               err_d    = 1'b1;
               retire_d = 1'b1;
               rpc_d    = pc_cap_q;
               state_d  = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rd_cap_q <= '0;
         funct3_q <= '0;
         off_q    <= '0;
         pc_cap_q <= '0;
         dest_q   <= '0;
         need_q   <= 1'b0;
         value_q  <= '0;
         retire_q <= 1'b0;
         rpc_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rd_cap_q <= rd_cap_d;
         funct3_q <= funct3_d;
         off_q    <= off_d;
         pc_cap_q <= pc_cap_d;
         dest_q   <= dest_d;
         need_q   <= need_d;
         value_q  <= value_d;
         retire_q <= retire_d;
         rpc_q    <= rpc_d;
         err_q    <= err_d;
      end
   end

   assign reg_write_dest       = dest_q;
   assign need_to_write        = need_q;
   assign reg_write_dest_value = value_q;
   assign retire_valid         = retire_q;
   assign retired_pc           = rpc_q;
   assign load_timeout_err     = err_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: stimulus pushes expected retires, a negedge monitor
// pops and compares them, and checks held outputs on idle cycles.
module tb_writeback_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_reg_write;
   logic        in_reg_write_from_load;
   logic [4:0]  in_rd;
   logic [31:0] in_alu_result;
   logic [2:0]  in_funct3;
   logic [31:0] in_pc_value;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic [4:0]  reg_write_dest;
   logic        need_to_write;
   logic [31:0] reg_write_dest_value;
   logic        retire_valid;
   logic [31:0] retired_pc;
   logic        load_timeout_err;

   writeback_unit #(.XLEN(32), .REG_ADDR_W(5), .LOAD_TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_reg_write(in_reg_write), .in_reg_write_from_load(in_reg_write_from_load),
      .in_rd(in_rd), .in_alu_result(in_alu_result), .in_funct3(in_funct3),
      .in_pc_value(in_pc_value), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .reg_write_dest(reg_write_dest), .need_to_write(need_to_write),
      .reg_write_dest_value(reg_write_dest_value), .retire_valid(retire_valid),
      .retired_pc(retired_pc), .load_timeout_err(load_timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        need;
      logic [4:0]  dest;
      logic [31:0] value;
      logic [31:0] pc;
      int          cyc;
      logic        dv;
   } exp_t;

   exp_t        q[$];
   int          cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   logic [4:0]  held_dest = '0;
   logic [31:0] held_value = '0;
   logic [31:0] held_pc = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops one expectation per retire pulse; between pulses outputs must hold.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         held_dest  = '0;
         held_value = '0;
         held_pc    = '0;
      end else if (retire_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_retire", {31'd0, retire_valid}, 32'd0);
         end else begin
            e = q.pop_front();
            $display("retire pc=0x%08h need=%0b dest=%0d value=0x%08h cyc=%0d",
                     retired_pc, need_to_write, reg_write_dest, reg_write_dest_value, cyc);
            chk("retire_cycle", cyc, e.cyc);
            chk("retired_pc", retired_pc, e.pc);
            chk("need_to_write", {31'd0, need_to_write}, {31'd0, e.need});
            if (e.dv) begin
               chk("dest", {27'd0, reg_write_dest}, {27'd0, e.dest});
               chk("value", reg_write_dest_value, e.value);
               held_dest  = e.dest;
               held_value = e.value;
            end else begin
               chk("dest_hold_on_timeout", {27'd0, reg_write_dest}, {27'd0, held_dest});
            end
            held_pc = e.pc;
         end
      end else begin
         chk("need_without_retire", {31'd0, need_to_write}, 32'd0);
         chk("hold_dest", {27'd0, reg_write_dest}, {27'd0, held_dest});
         chk("hold_value", reg_write_dest_value, held_value);
         chk("hold_pc", retired_pc, held_pc);
      end
   end

   task automatic send(input logic ld, input logic wr, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [2:0] f3,
                       input logic [31:0] pc, output int c);
      in_valid               = 1'b1;
      in_reg_write           = wr;
      in_reg_write_from_load = ld;
      in_rd                  = rd;
      in_alu_result          = alu;
      in_funct3              = f3;
      in_pc_value            = pc;
      c = cyc;
      #3 chk("ready_on_issue", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic alu_op(input logic wr, input logic [4:0] rd, input logic [31:0] val,
                         input logic [31:0] pc);
      exp_t e;
      int   c;
      send(1'b0, wr, rd, val, 3'b000, pc, c);
      e.need = wr && (rd != 5'd0); e.dest = rd; e.value = val; e.pc = pc;
      e.cyc = c + 1; e.dv = 1'b1;
      q.push_back(e);
   endtask

   // rvalid is driven on wait cycle dly; stray in_valid is offered before that and must be ignored.
   task automatic do_load(input logic [4:0] rd, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] pc, input logic [31:0] rdata, input int dly,
                          input logic [31:0] exp_val);
      exp_t e;
      int   c;
      send(1'b1, 1'b1, rd, addr, f3, pc, c);
      for (int k = 1; k < dly; k++) begin
         in_valid = 1'b1; in_reg_write_from_load = 1'b0; in_rd = 5'd9;
         in_alu_result = 32'hDEAD_BEEF; in_pc_value = 32'h0000_BAD0;
         #3 chk("ready_low_wait", {31'd0, in_ready}, 32'd0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = rdata;
      e.need = (rd != 5'd0); e.dest = rd; e.value = exp_val; e.pc = pc;
      e.cyc = cyc + 1; e.dv = 1'b1;
      q.push_back(e);
      #3 chk("ready_low_rvalid", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      chk("ready_after_load", {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   c;
      rst = 1'b1; in_valid = 1'b0; in_reg_write = 1'b0; in_reg_write_from_load = 1'b0;
      in_rd = '0; in_alu_result = '0; in_funct3 = '0; in_pc_value = '0;
      mem_rvalid = 1'b0; mem_rdata = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_ready", {31'd0, in_ready}, 32'd1);
      chk("reset_need", {31'd0, need_to_write}, 32'd0);
      chk("reset_retire", {31'd0, retire_valid}, 32'd0);
      chk("reset_err", {31'd0, load_timeout_err}, 32'd0);
      chk("reset_dest", {27'd0, reg_write_dest}, 32'd0);
      chk("reset_value", reg_write_dest_value, 32'd0);
      chk("reset_pc", retired_pc, 32'd0);

      alu_op(1'b1, 5'd5, 32'h0000_1234, 32'h100);
      alu_op(1'b1, 5'd6, 32'h0000_0011, 32'h104);
      alu_op(1'b1, 5'd7, 32'h0000_0022, 32'h108);
      alu_op(1'b1, 5'd8, 32'h0000_0033, 32'h10C);
      alu_op(1'b1, 5'd0, 32'h0000_FFFF, 32'h110);
      alu_op(1'b0, 5'd9, 32'h0000_0077, 32'h114);

      // mem_rvalid while idle must not retire anything
      mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
      @(posedge clk); #1 mem_rvalid = 1'b0;

      do_load(5'd10, 32'h0000_2003, 3'b000, 32'h200, 32'h80FF_0000, 1, 32'hFFFF_FF80);
      do_load(5'd11, 32'h0000_2002, 3'b101, 32'h204, 32'h80FF_0000, 1, 32'h0000_80FF);
      do_load(5'd12, 32'h0000_2000, 3'b000, 32'h208, 32'h1234_ABCD, 1, 32'hFFFF_FFCD);
      do_load(5'd13, 32'h0000_2001, 3'b100, 32'h20C, 32'h1234_ABCD, 2, 32'h0000_00AB);
      do_load(5'd14, 32'h0000_2003, 3'b001, 32'h210, 32'h1234_ABCD, 1, 32'h0000_1234);
      do_load(5'd15, 32'h0000_2001, 3'b001, 32'h214, 32'h1234_ABCD, 1, 32'hFFFF_ABCD);
      do_load(5'd16, 32'h0000_2000, 3'b101, 32'h218, 32'h1234_ABCD, 1, 32'h0000_ABCD);
      do_load(5'd17, 32'h0000_2003, 3'b010, 32'h21C, 32'h1234_ABCD, 4, 32'h1234_ABCD);
      do_load(5'd18, 32'h0000_2001, 3'b111, 32'h220, 32'h80FF_0000, 1, 32'h80FF_0000);
      do_load(5'd0,  32'h0000_2000, 3'b010, 32'h224, 32'h5555_AAAA, 1, 32'h5555_AAAA);
      alu_op(1'b1, 5'd19, 32'hA5A5_0001, 32'h228);

      // data on the final allowed wait cycle wins over the timeout
      do_load(5'd3, 32'h0000_0040, 3'b010, 32'h280, 32'hCAFE_F00D, 8, 32'hCAFE_F00D);
      chk("err_after_late_data", {31'd0, load_timeout_err}, 32'd0);

      send(1'b1, 1'b1, 5'd12, 32'h0000_0040, 3'b010, 32'h300, c);
      e.need = 1'b0; e.dest = '0; e.value = '0; e.pc = 32'h300; e.cyc = c + 9; e.dv = 1'b0;
      q.push_back(e);
      for (int k = 1; k <= 8; k++) begin
         #3;
         chk("ready_low_timeout", {31'd0, in_ready}, 32'd0);
         chk("err_before_timeout", {31'd0, load_timeout_err}, 32'd0);
         @(posedge clk); #1;
      end
      chk("err_after_timeout", {31'd0, load_timeout_err}, 32'd1);
      chk("ready_after_timeout", {31'd0, in_ready}, 32'd1);
      alu_op(1'b1, 5'd20, 32'h0BAD_CAFE, 32'h304);
      @(posedge clk); #1;
      chk("err_sticky", {31'd0, load_timeout_err}, 32'd1);

      // reset in the middle of a load wait abandons it
      send(1'b1, 1'b1, 5'd7, 32'h0000_0000, 3'b010, 32'h400, c);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_wait_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_wait_err", {31'd0, load_timeout_err}, 32'd0);
      chk("rst_wait_need", {31'd0, need_to_write}, 32'd0);
      chk("rst_wait_retire", {31'd0, retire_valid}, 32'd0);
      mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      @(posedge clk); #1 mem_rvalid = 1'b0;
      alu_op(1'b1, 5'd1, 32'h0000_0055, 32'h500);

      repeat (3) @(posedge clk);
      #1 chk("queue_drained", q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
